// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, quarter-phase codes and bus constants
// for the single-master I2C transaction sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_STOP,
    S_DONE
  } i2c_state_t;

  typedef logic [1:0] qphase_t;

  localparam qphase_t Q0 = 2'd0;
  localparam qphase_t Q1 = 2'd1;
  localparam qphase_t Q2 = 2'd2;
  localparam qphase_t Q3 = 2'd3;

  localparam logic [6:0] I2C_DEF_ADDR = 7'h2A;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: DIV-clock quarter strobe and 2-bit slot phase.
// i_stall freezes the count (clock stretching under I2C_CLK_STRETCH_EN).
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_clr,
  input  logic    i_stall,
  output logic    o_tick,
  output qphase_t o_phase
);

  logic [15:0] r_cnt;
  qphase_t     r_phase;
  logic        w_wrap;

  assign w_wrap  = (r_cnt == 16'(DIV - 1));
  assign o_tick  = w_wrap && !i_stall && !i_clr;
  assign o_phase = r_phase;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt   <= '0;
      r_phase <= Q0;
    end else if (!i_stall) begin
      if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: one-byte I2C write/read sequencer on open-drain scl/sda.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching in q1.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int         DIV      = 4,
  parameter logic [6:0] DEF_ADDR = I2C_DEF_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rw,
  input  logic       addr_sel,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);

  i2c_state_t r_state, w_state_nxt;
  logic       r_busy, r_done, r_ack_err;
  logic       r_rw, r_smp;
  logic [6:0] r_addr;
  logic [7:0] r_wdata, r_shift, r_rdata;
  logic [2:0] r_bitcnt;

  logic       w_accept, w_clr, w_stall;
  logic       w_tick, w_slot_end, w_sample;
  logic       w_bit_scl_lo, w_scl_lo, w_sda_lo;
  qphase_t    w_phase;
  logic [7:0] w_addr_byte;

  assign w_accept     = (r_state == S_IDLE) && req && !r_busy;
  assign w_clr        = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_slot_end   = w_tick && (w_phase == Q3);
  assign w_sample     = w_tick && (w_phase == Q2);
  assign w_bit_scl_lo = (w_phase == Q0) || (w_phase == Q3);
  assign w_addr_byte  = {r_addr, r_rw};

`ifdef I2C_CLK_STRETCH_EN
  assign w_stall = (w_phase == Q1) && !w_clr && (scl == 1'b0);
`else
  assign w_stall = 1'b0;
`endif

  i2c_qtick_gen #(.DIV(DIV)) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_stall (w_stall),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scl_lo    = 1'b0;
    w_sda_lo    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        w_scl_lo = (w_phase == Q3);
        w_sda_lo = w_phase[1];
        if (w_slot_end) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_scl_lo = w_bit_scl_lo;
        w_sda_lo = !w_addr_byte[r_bitcnt];
        if (w_slot_end && r_bitcnt == 3'd0)
          w_state_nxt = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        w_scl_lo = w_bit_scl_lo;
        if (w_slot_end)
          w_state_nxt = r_smp ? S_STOP : S_DATA;
      end
      S_DATA: begin
        w_scl_lo = w_bit_scl_lo;
        w_sda_lo = (r_rw == RW_WRITE) && !r_wdata[r_bitcnt];
        if (w_slot_end && r_bitcnt == 3'd0)
          w_state_nxt = S_DATA_ACK;
      end
      S_DATA_ACK: begin
        // sda stays released: slave ACK on write, master NACK on read
        w_scl_lo = w_bit_scl_lo;
        if (w_slot_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_scl_lo = (w_phase == Q0);
        w_sda_lo = !w_phase[1];
        if (w_slot_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rw      <= RW_WRITE;
      r_addr    <= DEF_ADDR;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_rdata   <= '0;
      r_bitcnt  <= '0;
      r_smp     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_ack_err <= 1'b0;
        r_rw      <= rw;
        r_addr    <= addr_sel ? addr : DEF_ADDR;
        r_wdata   <= wdata;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_sample) begin
        r_smp <= sda;
        if (r_state == S_DATA) r_shift <= {r_shift[6:0], sda};
      end
      if (w_slot_end) begin
        case (r_state)
          S_START:        r_bitcnt <= 3'd7;
          S_ADDR, S_DATA: r_bitcnt <= r_bitcnt - 3'd1;
          S_ADDR_ACK: begin
            if (r_smp) r_ack_err <= 1'b1;
          end
          S_DATA_ACK: begin
            if (r_rw == RW_WRITE && r_smp) r_ack_err <= 1'b1;
            if (r_rw == RW_READ) r_rdata <= r_shift;
          end
          default: ;
        endcase
      end
    end
  end

  assign scl     = w_scl_lo ? 1'b0 : 1'bz;
  assign sda     = w_sda_lo ? 1'b0 : 1'bz;
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: scoreboard bench with a bus-level slave at 7'h2A.
// Define I2C_CLK_STRETCH_EN to add the clock-stretch scenario.
module tb_i2c_master_ctrl;

  localparam int DIV      = 4;
  localparam int LAT      = 80 * DIV + 1;
  localparam int LAT_NACK = 44 * DIV + 1;
  localparam logic [6:0] SLV = 7'h2A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic       addr_sel = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  wire        scl, sda;

  logic s_lo = 1'b0;
  logic tb_scl_lo = 1'b0;

  assign sda = s_lo ? 1'b0 : 1'bz;
  assign scl = tb_scl_lo ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  i2c_master_ctrl #(.DIV(DIV), .DEF_ADDR(SLV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rw       (rw),
    .addr_sel (addr_sel),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl      (scl),
    .sda      (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         lat;
    logic       aerr;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: pops the scoreboard on every done pulse.
  logic prev_busy = 1'b0;
  int   acc_cyc = 0;
  int   fall_cyc = 0;
  int   done_cnt = 0;
  int   n_acc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (busy && !prev_busy) begin
      acc_cyc = cyc;
      n_acc++;
    end
    if (!busy && prev_busy) fall_cyc = cyc;
    prev_busy = busy;
    if (done) begin
      done_cnt++;
      chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        chk("ack_err", 32'(ack_err), 32'(e.aerr));
        chk("rdata", 32'(rdata), 32'(e.rd));
      end
    end
  end

  // Bus-level slave: ACKs SLV, returns s_tx on reads.
  int         s_nbits = 0;
  int         s_starts = 0;
  int         s_stops = 0;
  int         s_next = 0;
  logic       s_active = 1'b0;
  logic       s_match = 1'b0;
  logic       s_rw = 1'b0;
  logic       s_aack = 1'b0;
  logic       s_ack18 = 1'b0;
  logic [7:0] s_abyte = '0;
  logic [7:0] s_din = '0;
  logic [7:0] s_tx = 8'hCC;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;

  always @(scl or sda) begin
    if (scl === 1'b1 && p_scl === 1'b1 &&
        p_sda === 1'b1 && sda === 1'b0) begin
      s_active = 1'b1;
      s_nbits  = 0;
      s_match  = 1'b0;
      s_starts++;
    end else if (scl === 1'b1 && p_scl === 1'b1 &&
                 p_sda === 1'b0 && sda === 1'b1) begin
      if (s_active) s_stops++;
      s_active = 1'b0;
      s_lo     = 1'b0;
    end else if (p_scl === 1'b0 && scl === 1'b1 && s_active) begin
      s_nbits++;
      if (s_nbits <= 8) s_abyte = {s_abyte[6:0], sda === 1'b1};
      if (s_nbits == 8) begin
        s_match = (s_abyte[7:1] == SLV);
        s_rw    = s_abyte[0];
      end
      if (s_nbits == 9) s_aack = (sda === 1'b1);
      if (s_match && !s_rw && s_nbits >= 10 && s_nbits <= 17)
        s_din = {s_din[6:0], sda === 1'b1};
      if (s_match && s_nbits == 18) s_ack18 = (sda === 1'b1);
    end else if (p_scl === 1'b1 && scl === 1'b0 && s_active) begin
      s_next = s_nbits + 1;
      s_lo   = 1'b0;
      if (s_match && s_next == 9)
        s_lo = 1'b1;
      else if (s_match && s_rw && s_next >= 10 && s_next <= 17)
        s_lo = !s_tx[17 - s_next];
      else if (s_match && !s_rw && s_next == 18)
        s_lo = 1'b1;
    end
    p_scl = scl;
    p_sda = sda;
  end

  task automatic start_txn(input logic t_rw, input logic t_sel,
                           input logic [6:0] t_addr,
                           input logic [7:0] t_wd);
    @(negedge clk);
    rw       = t_rw;
    addr_sel = t_sel;
    addr     = t_addr;
    wdata    = t_wd;
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_cnt >= target), 1);
  endtask

  initial begin
    int s0, st0, a0, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_scl", 32'(scl === 1'b1), 1);
    chk("rst_sda", 32'(sda === 1'b1), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write ACK to default address
    exp_q.push_back('{LAT, 1'b0, 8'h00});
    st0 = s_stops;
    start_txn(1'b0, 1'b0, 7'h00, 8'h5A);
    wait_done(1);
    chk("t1_addr_byte", 32'(s_abyte), 32'h54);
    chk("t1_slave_data", 32'(s_din), 32'h5A);
    chk("t1_addr_ack", 32'(s_aack), 0);
    chk("t1_data_ack", 32'(s_ack18), 0);
    chk("t1_stop", 32'(s_stops - st0), 1);
    repeat (3) @(negedge clk);

    // read from default address
    exp_q.push_back('{LAT, 1'b0, 8'hCC});
    start_txn(1'b1, 1'b0, 7'h00, 8'h00);
    wait_done(2);
    chk("t2_addr_byte", 32'(s_abyte), 32'h55);
    chk("t2_master_nack", 32'(s_ack18), 1);
    repeat (3) @(negedge clk);

    // address NACK
    exp_q.push_back('{LAT_NACK, 1'b1, 8'hCC});
    st0 = s_stops;
    start_txn(1'b0, 1'b1, 7'h15, 8'h77);
    wait_done(3);
    chk("t3_addr_byte", 32'(s_abyte), 32'h2A);
    chk("t3_addr_nack", 32'(s_aack), 1);
    chk("t3_stop", 32'(s_stops - st0), 1);
    repeat (3) @(negedge clk);

    // req pulse while busy is dropped
    exp_q.push_back('{LAT, 1'b0, 8'hCC});
    s0 = s_starts;
    a0 = n_acc;
    start_txn(1'b0, 1'b0, 7'h00, 8'h11);
    repeat (100) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done(4);
    repeat (20) @(negedge clk);
    chk("t4_accepts", 32'(n_acc - a0), 1);
    chk("t4_starts", 32'(s_starts - s0), 1);
    chk("t4_idle", 32'(busy), 0);

    // req held high through done
    exp_q.push_back('{LAT, 1'b0, 8'hCC});
    exp_q.push_back('{LAT, 1'b0, 8'hCC});
    a0 = n_acc;
    @(negedge clk);
    rw = 1'b0; addr_sel = 1'b0; wdata = 8'h3C; req = 1'b1;
    n = 0;
    while (n_acc < a0 + 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    chk("t4_b2b_accepts", 32'(n_acc - a0), 2);
    chk("t4_b2b_gap", 32'(acc_cyc - fall_cyc), 1);
    wait_done(6);
    chk("t4_b2b_data", 32'(s_din), 32'h3C);
    repeat (3) @(negedge clk);

    // reset during the 3rd data bit
    start_txn(1'b0, 1'b0, 7'h00, 8'h33);
    @(negedge clk);
    while (cyc < acc_cyc + 50 * DIV) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_scl", 32'(scl === 1'b1), 1);
    chk("t5_sda", 32'(sda === 1'b1), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back('{LAT, 1'b0, 8'h00});
    start_txn(1'b0, 1'b0, 7'h00, 8'hA5);
    wait_done(7);
    chk("t5_addr_byte", 32'(s_abyte), 32'h54);
    chk("t5_slave_data", 32'(s_din), 32'hA5);
    repeat (3) @(negedge clk);

`ifdef I2C_CLK_STRETCH_EN
    // hold scl low for 10 clks of q1 in the ADDR_ACK slot
    exp_q.push_back('{LAT + 10, 1'b0, 8'h00});
    start_txn(1'b0, 1'b0, 7'h00, 8'hC3);
    @(negedge clk);
    while (cyc < acc_cyc + 37 * DIV - 1) @(negedge clk);
    tb_scl_lo = 1'b1;
    while (cyc < acc_cyc + 37 * DIV + 10) @(negedge clk);
    tb_scl_lo = 1'b0;
    wait_done(8);
    chk("t6_slave_data", 32'(s_din), 32'hC3);
    repeat (3) @(negedge clk);
`endif

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
